// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU tile: op codes, FSM states,
// flag bit positions and uio pin indices.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_SLT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_OUT    = 2'd3
  } state_e;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 3;

  localparam int unsigned CTL_STB    = 0;
  localparam int unsigned CTL_OP_LSB = 1;
  localparam int unsigned CTL_CLR    = 4;
  localparam int unsigned ST_BUSY    = 5;
  localparam int unsigned ST_RDY     = 6;
  localparam int unsigned ST_VALID   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'b1110_0000;

endpackage

// File: rtl/alu_seq_byteio_core.sv
// Combinational WIDTH-bit ALU: eight ops with Z/C/N/V flags.
module alu_core_w
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SW-1:0]    shamt;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shamt  = b[SW-1:0];
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase

    flags        = '0;
    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = result[WIDTH-1];
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_seq_byteio.sv
// Byte-serial ALU tile: loads A and B LSB byte first, executes in one
// registered cycle, then streams result bytes and a flags byte out.
module alu_seq_byteio
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned CW = $clog2(NB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_FLG  = CW'(NB);

  state_e           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n, res_q, res_n;
  op_e              op_q, op_n;
  logic [3:0]       flg_q, flg_n;
  logic             valid_q, valid_n;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flg;
  logic [CW+2:0]    bsh;
  logic [WIDTH-1:0] byte_mask, in_word, res_shift;
  logic             stb, clr;
  logic             unused_ctl;

  assign stb        = uio_in[CTL_STB];
  assign clr        = uio_in[CTL_CLR];
  assign unused_ctl = &{1'b0, uio_in[7:5]};

  assign bsh       = {cnt, 3'b000};
  assign byte_mask = WIDTH'(8'hFF) << bsh;
  assign in_word   = WIDTH'(ui_in) << bsh;
  assign res_shift = res_q >> bsh;

  alu_core_w #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .flags  (alu_flg)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    res_n   = res_q;
    flg_n   = flg_q;
    valid_n = valid_q;
    if (clr) begin
      state_n = S_LOAD_A;
      cnt_n   = '0;
      a_n     = '0;
      b_n     = '0;
      op_n    = OP_ADD;
      res_n   = '0;
      flg_n   = '0;
      valid_n = 1'b0;
    end else begin
      case (state)
        S_LOAD_A: if (stb) begin
          a_n = (a_q & ~byte_mask) | in_word;
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = S_LOAD_B;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_LOAD_B: if (stb) begin
          b_n = (b_q & ~byte_mask) | in_word;
          if (cnt == CNT_LAST) begin
            op_n    = op_e'(uio_in[CTL_OP_LSB +: 3]);
            cnt_n   = '0;
            state_n = S_EXEC;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_EXEC: begin
          res_n   = alu_res;
          flg_n   = alu_flg;
          cnt_n   = '0;
          state_n = S_OUT;
        end
        S_OUT: begin
          // First OUT cycle only raises out_valid; strobes count from then on.
          if (!valid_q) begin
            valid_n = 1'b1;
          end else if (stb) begin
            if (cnt == CNT_FLG) begin
              valid_n = 1'b0;
              cnt_n   = '0;
              state_n = S_LOAD_A;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: state_n = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOAD_A;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flg_q   <= '0;
      valid_q <= 1'b0;
    end else if (ena) begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      res_q   <= res_n;
      flg_q   <= flg_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    uo_out = '0;
    if (valid_q) begin
      uo_out = (cnt == CNT_FLG) ? {4'b0000, flg_q} : res_shift[7:0];
    end
    uio_out           = '0;
    uio_out[ST_VALID] = valid_q;
    uio_out[ST_RDY]   = (state == S_LOAD_A) || (state == S_LOAD_B);
    uio_out[ST_BUSY]  = (state == S_EXEC) || (state == S_OUT);
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_alu_seq_byteio.sv
// Self-checking bench for alu_seq_byteio (WIDTH=16) against an arithmetic model.
module tb_alu_seq_byteio;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  alu_seq_byteio #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic over the op definitions.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [7:0] fl);
    int ua, ub, sa, sb, full, ss;
    bit c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 0; v = 0; full = 0;
    case (op)
      3'd0: begin full = ua + ub; c = (full > 65535); ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
      3'd1: begin full = ua - ub; c = (ua < ub);     ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: full = ua << (ub % 16);
      3'd6: full = ua >> (ub % 16);
      default: full = (sa < sb) ? 1 : 0;
    endcase
    r  = full[15:0];
    fl = {4'b0000, v, r[15], c, (r == 16'h0000)};
  endfunction

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w      = (i < 2) ? a : b;
      ui_in  = w[8*(i%2) +: 8];
      uio_in = {3'b000, 1'b0, op, 1'b1};
      step();
    end
    uio_in = 8'h00;
  endtask

  // Called right after the last B strobe edge; checks latency and the byte stream.
  task automatic read_out(input logic [15:0] r, input logic [7:0] fl, input string tag);
    n_chk++;
    if (uio_out !== 8'h20) $display("FAIL %s exec_status: got %h want 20", tag, uio_out);
    else n_pass++;
    step();
    n_chk++;
    if (uio_out[7] !== 1'b0) $display("FAIL %s early_valid: got %b want 0", tag, uio_out[7]);
    else n_pass++;
    step();
    n_chk++;
    if (uio_out[7] !== 1'b1 || uo_out !== r[7:0])
      $display("FAIL %s byte0: got valid=%b uo=%h want valid=1 uo=%h", tag, uio_out[7], uo_out, r[7:0]);
    else n_pass++;
    uio_in = 8'h01;
    step();
    n_chk++;
    if (uo_out !== r[15:8]) $display("FAIL %s byte1: got %h want %h", tag, uo_out, r[15:8]);
    else n_pass++;
    step();
    n_chk++;
    if (uo_out !== fl) $display("FAIL %s flags: got %h want %h", tag, uo_out, fl);
    else n_pass++;
    step();
    uio_in = 8'h00;
    n_chk++;
    if (uio_out !== 8'h40 || uo_out !== 8'h00)
      $display("FAIL %s done: got uio=%h uo=%h want uio=40 uo=00", tag, uio_out, uo_out);
    else n_pass++;
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input string tag);
    logic [15:0] r;
    logic [7:0]  fl;
    model(op, a, b, r, fl);
    load_ops(a, b, op);
    read_out(r, fl, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    step(); step();
    n_chk++;
    if (uo_out !== 8'h00 || uio_out !== 8'h40 || uio_oe !== 8'hE0)
      $display("FAIL reset: got uo=%h uio=%h oe=%h want 00 40 e0", uo_out, uio_out, uio_oe);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [15:0] r;
    logic [7:0]  fl;
    model(3'd0, 16'h1234, 16'h0FFF, r, fl);
    n_chk++;
    if (r !== 16'h2233 || fl !== 8'h00) $display("FAIL model_add: got %h/%h want 2233/00", r, fl);
    else n_pass++;
    run_txn(16'h1234, 16'h0FFF, 3'd0, "add");
    run_txn(16'h0001, 16'h0002, 3'd1, "sub_neg");
    run_txn(16'h0005, 16'h0005, 3'd1, "sub_zero");
    run_txn(16'h7FFF, 16'h0001, 3'd0, "add_ovf");
    run_txn(16'h0001, 16'h001F, 3'd5, "shl15");
    run_txn(16'hFFFF, 16'h0001, 3'd7, "slt");
    run_txn(16'h8000, 16'h0013, 3'd6, "shr3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_txn(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), "rand");
  endtask

  task automatic test_stb_held();
    logic [15:0] a, b, r, w;
    logic [7:0]  fl;
    logic [7:0]  exp_q[$];
    a = 16'($urandom); b = 16'($urandom);
    model(3'd1, a, b, r, fl);
    uio_in = {3'b000, 1'b0, 3'd1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      w     = (i < 2) ? a : b;
      ui_in = w[8*(i%2) +: 8];
      step();
    end
    exp_q = '{r[7:0], r[15:8], fl};
    step(); step();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (uio_out[7] !== 1'b1 || uo_out !== exp_q[i])
        $display("FAIL held_byte%0d: got valid=%b uo=%h want valid=1 uo=%h", i, uio_out[7], uo_out, exp_q[i]);
      else n_pass++;
      step();
    end
    uio_in = 8'h00;
    n_chk++;
    if (uio_out !== 8'h40) $display("FAIL held_done: got %h want 40", uio_out);
    else n_pass++;
  endtask

  task automatic test_ena_freeze();
    logic [15:0] a, b, r;
    logic [7:0]  fl;
    a = 16'($urandom); b = 16'($urandom);
    model(3'd4, a, b, r, fl);
    uio_in = {3'b000, 1'b0, 3'd4, 1'b1};
    ui_in = a[7:0];  step();
    ui_in = a[15:8]; step();
    ui_in = b[7:0];  step();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ui_in  = 8'($urandom);
      uio_in = {3'b000, 1'b0, 3'($urandom), 1'b1};
      step();
    end
    n_chk++;
    if (uio_out !== 8'h40 || uo_out !== 8'h00)
      $display("FAIL freeze_hold: got uio=%h uo=%h want 40 00", uio_out, uo_out);
    else n_pass++;
    ena = 1'b1;
    ui_in = b[15:8]; uio_in = {3'b000, 1'b0, 3'd4, 1'b1};
    step();
    uio_in = 8'h00;
    read_out(r, fl, "freeze");
  endtask

  task automatic test_clear();
    ui_in = 8'hA5; uio_in = 8'h01; step();
    ui_in = 8'h5A; uio_in = 8'h11; step();
    uio_in = 8'h00;
    n_chk++;
    if (uio_out !== 8'h40 || uo_out !== 8'h00)
      $display("FAIL clear: got uio=%h uo=%h want 40 00", uio_out, uo_out);
    else n_pass++;
    run_txn(16'($urandom), 16'($urandom), 3'd0, "after_clear");
  endtask

  task automatic test_async_reset();
    load_ops(16'h1234, 16'h0FFF, 3'd0);
    step(); step();
    n_chk++;
    if (uio_out[7] !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", uio_out[7]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (uo_out !== 8'h00 || uio_out !== 8'h40)
      $display("FAIL async_reset: got uo=%h uio=%h want 00 40", uo_out, uio_out);
    else n_pass++;
    #10 rst_n = 1'b1;
    step();
    run_txn(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stb_held();
    test_ena_freeze();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
